// File: rtl/io_pkg.sv
// Shared constants for the switch input stage: switch count and the 32-bit
// I/O port word layout (two 5-bit halves, zero-filled above).
package io_pkg;

  localparam int IO_NBITS       = 10;
  localparam int IO_PORT_W      = 32;
  localparam int IO_PORT_SPLIT  = 5;
  localparam int IO_PORT_ZERO_W = IO_PORT_W - IO_PORT_SPLIT;

  // Zero-extends one switch half into a full port word.
  function automatic logic [IO_PORT_W-1:0] pack_port(input logic [IO_PORT_SPLIT-1:0] half);
    return {{IO_PORT_ZERO_W{1'b0}}, half};
  endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch bit: SYNC_STAGES-deep synchroniser, stability counter and the
// debounced level. upd pulses combinationally on the edge stable flips.
module switch_debounce_bit #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  parameter int CNT_W       = $clog2(DB_CYCLES + 1)
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw,
  output logic stable,
  output logic upd
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_stable;
  logic                   w_sync;
  logic                   w_diff;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_diff = (w_sync != r_stable);
  assign upd    = w_diff && (r_cnt == CNT_LAST);
  assign stable = r_stable;

  // NOTE: non-blocking assignments make every stage sample its pre-edge
  // neighbour, so the chain advances exactly one stage per clock edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (!w_diff) begin
      r_cnt <= '0;
    end else if (upd) begin
      r_stable <= w_sync;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/io_switch_conditioner.sv
// Switch input stage: per-bit debounce, port packing and a sticky change flag.
// Optional IO_SWITCH_RISE_LATCH_EN adds a per-bit sticky rising-edge latch.
module io_switch_conditioner
  import io_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [IO_NBITS-1:0]  sw_raw,
  input  logic                 change_ack,
  output logic [IO_NBITS-1:0]  stable,
  output logic [IO_PORT_W-1:0] in_port0,
  output logic [IO_PORT_W-1:0] in_port1,
`ifdef IO_SWITCH_RISE_LATCH_EN
  output logic [IO_NBITS-1:0]  rise_latch,
`endif
  output logic                 changed
);

  localparam int NBITS = IO_NBITS;
  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  logic [NBITS-1:0] w_upd;
  logic             r_changed;

  for (genvar g = 0; g < NBITS; g++) begin : g_bit
    switch_debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES),
      .CNT_W       (CNT_W)
    ) u_bit (
      .clk    (clk),
      .resetn (resetn),
      .raw    (sw_raw[g]),
      .stable (stable[g]),
      .upd    (w_upd[g])
    );
  end

  assign in_port0 = pack_port(stable[IO_PORT_SPLIT-1:0]);
  assign in_port1 = pack_port(stable[NBITS-1:IO_PORT_SPLIT]);
  assign changed  = r_changed;

  // A fresh update outranks an acknowledge arriving on the same edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_changed <= 1'b0;
    end else if (|w_upd) begin
      r_changed <= 1'b1;
    end else if (change_ack) begin
      r_changed <= 1'b0;
    end
  end

`ifdef IO_SWITCH_RISE_LATCH_EN
  logic [NBITS-1:0] w_rise;
  logic [NBITS-1:0] r_rise_latch;

  // An updating bit that is currently 0 is about to become 1.
  assign w_rise     = w_upd & ~stable;
  assign rise_latch = r_rise_latch;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rise_latch <= '0;
    end else if (change_ack) begin
      r_rise_latch <= w_rise;
    end else begin
      r_rise_latch <= r_rise_latch | w_rise;
    end
  end
`endif

endmodule

// File: tb/tb_io_switch_conditioner.sv
// Scoreboard bench: a sliding-window reference model predicts every cycle's
// outputs; a negedge monitor pops and compares them, plus directed checks.
module tb_io_switch_conditioner;
  import io_pkg::*;

  localparam int SYNC = 2;
  localparam int DB   = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        change_ack;
  logic [9:0]  sw_raw;
  logic [9:0]  stable;
  logic [31:0] in_port0;
  logic [31:0] in_port1;
  logic        changed;
`ifdef IO_SWITCH_RISE_LATCH_EN
  logic [9:0]  rise_latch;
`endif

  int tests = 0;
  int fails = 0;

  io_switch_conditioner #(.SYNC_STAGES(SYNC), .DB_CYCLES(DB)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .sw_raw     (sw_raw),
    .change_ack (change_ack),
    .stable     (stable),
    .in_port0   (in_port0),
    .in_port1   (in_port1),
`ifdef IO_SWITCH_RISE_LATCH_EN
    .rise_latch (rise_latch),
`endif
    .changed    (changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Advance n falling edges, then settle 1 time unit (driving/check point).
  task automatic edges(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    change_ack = 1'b1;
    edges(1);
    change_ack = 1'b0;
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [9:0] stable;
    logic       changed;
    logic [9:0] rise;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] m_hist[$];   // m_hist[k]: raw sampled k edges ago
  logic [9:0] m_stable;
  logic       m_changed;
  logic [9:0] m_rise;
  logic [9:0] m_upd;
  logic       m_all_diff;

  // A bit adopts the synchronised value once the last DB synchronised
  // samples all disagree with it; sync at edge n is raw sampled at n-SYNC.
  initial forever begin
    @(posedge clk);
    if (!resetn) begin
      m_hist = {};
      for (int k = 0; k < SYNC + DB; k++) m_hist.push_back(10'h000);
      m_stable  = '0;
      m_changed = 1'b0;
      m_rise    = '0;
    end else begin
      m_hist.push_front(sw_raw);
      m_upd = '0;
      for (int i = 0; i < 10; i++) begin
        m_all_diff = 1'b1;
        for (int j = 0; j < DB; j++)
          if (m_hist[SYNC + j][i] == m_stable[i]) m_all_diff = 1'b0;
        m_upd[i] = m_all_diff;
      end
      if (change_ack) m_rise = m_upd & ~m_stable;
      else            m_rise = m_rise | (m_upd & ~m_stable);
      m_stable = m_stable ^ m_upd;
      if (m_upd != 0)      m_changed = 1'b1;
      else if (change_ack) m_changed = 1'b0;
      void'(m_hist.pop_back());
    end
    exp_q.push_back('{stable: m_stable, changed: m_changed, rise: m_rise});
  end

  exp_t e;
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_stable",  {22'b0, stable},   {22'b0, e.stable});
      check("sb_changed", {31'b0, changed},  {31'b0, e.changed});
      check("sb_port0",   in_port0, {27'b0, e.stable[4:0]});
      check("sb_port1",   in_port1, {27'b0, e.stable[9:5]});
`ifdef IO_SWITCH_RISE_LATCH_EN
      check("sb_rise",    {22'b0, rise_latch}, {22'b0, e.rise});
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  int hold;
  int cyc;
  bit did_reset;

  initial begin
    resetn     = 1'b0;
    change_ack = 1'b0;
    sw_raw     = 10'h000;
    edges(3);
    resetn = 1'b1;
    edges(10);
    check("reset_stable",  {22'b0, stable}, 32'h0);
    check("reset_changed", {31'b0, changed}, 32'h0);

    // 1. async reset mid-count, then 6-edge latency after release
    sw_raw = 10'h3FF;
    edges(3);
    resetn = 1'b0;
    #1;
    check("async_rst_stable",  {22'b0, stable}, 32'h0);
    check("async_rst_changed", {31'b0, changed}, 32'h0);
    check("async_rst_port0",   in_port0, 32'h0);
    check("async_rst_port1",   in_port1, 32'h0);
    edges(2);
    resetn = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      edges(1);
      check("post_rst_hold", {22'b0, stable}, 32'h0);
    end
    edges(1);
    check("post_rst_edge6",  {22'b0, stable}, 32'h3FF);
    check("post_rst_changed", {31'b0, changed}, 32'h1);
    sw_raw = 10'h000;
    edges(10);
    ack_pulse();
    edges(1);
    check("clear_changed", {31'b0, changed}, 32'h0);

    // 2. steady single-bit change
    sw_raw = 10'h001;
    for (int k = 1; k <= 5; k++) begin
      edges(1);
      check("lat_stable_early",  {22'b0, stable}, 32'h0);
      check("lat_changed_early", {31'b0, changed}, 32'h0);
    end
    edges(1);
    check("lat_stable",  {22'b0, stable}, 32'h001);
    check("lat_port0",   in_port0, 32'h1);
    check("lat_port1",   in_port1, 32'h0);
    check("lat_changed", {31'b0, changed}, 32'h1);
    sw_raw = 10'h000;
    edges(10);
    ack_pulse();
    edges(1);

    // 3. glitch rejection, then a long-enough pulse
    sw_raw = 10'h020;
    edges(3);
    sw_raw = 10'h000;
    edges(50);
    check("glitch_stable",  {22'b0, stable}, 32'h0);
    check("glitch_changed", {31'b0, changed}, 32'h0);
    sw_raw = 10'h020;
    edges(6);
    sw_raw = 10'h000;
    edges(2);
    check("pulse6_stable", {22'b0, stable}, 32'h020);
    check("pulse6_port1",  in_port1, 32'h1);
    edges(10);
    ack_pulse();
    edges(1);

    // 4. full vector, both ports on the same edge
    sw_raw = 10'h3FF;
    edges(5);
    check("full_port0_early", in_port0, 32'h0);
    edges(1);
    check("full_port0",   in_port0, 32'h1F);
    check("full_port1",   in_port1, 32'h1F);
    check("full_changed", {31'b0, changed}, 32'h1);
    ack_pulse();
    check("full_ack", {31'b0, changed}, 32'h0);

    // 5. ack coincident with an update: set wins
    sw_raw = 10'h3F7;
    edges(5);
    ack_pulse();
    check("simul_stable",  {22'b0, stable}, 32'h3F7);
    check("simul_changed", {31'b0, changed}, 32'h1);
    ack_pulse();
    check("simul_ack2", {31'b0, changed}, 32'h0);

`ifdef IO_SWITCH_RISE_LATCH_EN
    // 6. rise latch persists after bits fall, ack clears it
    sw_raw = 10'h000;
    edges(10);
    ack_pulse();
    sw_raw = 10'h201;
    edges(8);
    sw_raw = 10'h000;
    edges(8);
    check("rise_persist", {22'b0, rise_latch}, 32'h201);
    check("rise_stable",  {22'b0, stable}, 32'h0);
    ack_pulse();
    check("rise_cleared", {22'b0, rise_latch}, 32'h0);
`endif

    // randomized traffic, one reset in the middle
    cyc       = 0;
    did_reset = 1'b0;
    while (cyc < 800) begin
      hold = int'($urandom_range(1, 8));
      if ($urandom_range(0, 2) == 0) sw_raw = 10'($urandom_range(0, 1023));
      else                           sw_raw = sw_raw ^ (10'(1) << $urandom_range(0, 9));
      for (int h = 0; h < hold; h++) begin
        change_ack = ($urandom_range(0, 5) == 0);
        edges(1);
        cyc++;
      end
      if (cyc > 400 && !did_reset) begin
        did_reset  = 1'b1;
        change_ack = 1'b0;
        resetn     = 1'b0;
        edges(2);
        resetn = 1'b1;
      end
    end
    change_ack = 1'b0;
    edges(12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
